// File: rtl/dmem_responder.sv
// Single-cycle data memory responder: word RAM with byte-lane stores plus an optional
// MMIO window (cycle counter, snapshot shadow, TOHOST/Halt) compiled in by DMEM_MMIO_EN.
module dmem_responder #(
  parameter int          XLEN        = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWrite,
  input  logic [3:0]      MemWriteSelect,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] ReadData,
  output logic            Halt,
  output logic            AddrErr
);
  localparam int              AW        = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(DEPTH_WORDS * 4);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] read_data_q, read_data_d;
  logic            addr_err_q, addr_err_d;

  logic            ram_hit, ram_we, mmio_hit;
  logic [AW-1:0]   word_idx;
  logic [XLEN-1:0] ram_word, mmio_rdata;
  logic            unused_bits;

  assign unused_bits = ^{Addr[1:0], MMIO_BASE};

  always_comb begin
    ram_hit  = (Addr < RAM_BYTES);
    word_idx = Addr[AW+1:2];
    ram_word = mem_q[word_idx];
    for (int i = 0; i < 4; i++) begin
      if (MemWrite && MemWriteSelect[i]) ram_word[8*i +: 8] = WriteData[8*i +: 8];
    end
    // Reset must win over a same-cycle store, so the write enable is gated here.
    ram_we = ram_hit && MemWrite && (MemWriteSelect != 4'b0000) && !reset;
  end

`ifdef DMEM_MMIO_EN
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] tohost_q, tohost_d, tohost_wr;
  logic        halt_q, halt_d;

  always_comb begin
    mmio_hit   = (Addr[31:4] == MMIO_BASE[31:4]);
    cycle_d    = cycle_q + 64'd1;
    shadow_d   = shadow_q;
    tohost_d   = tohost_q;
    halt_d     = halt_q | (tohost_q != 32'd0);
    mmio_rdata = '0;
    tohost_wr  = tohost_q;
    for (int i = 0; i < 4; i++) begin
      if (MemWrite && MemWriteSelect[i]) tohost_wr[8*i +: 8] = WriteData[8*i +: 8];
    end
    if (mmio_hit) begin
      case (Addr[3:2])
        2'd0: begin
          mmio_rdata = XLEN'(cycle_q[31:0]);
          shadow_d   = cycle_q[63:32];
        end
        2'd1: mmio_rdata = XLEN'(shadow_q);
        2'd2: begin
          mmio_rdata = XLEN'(tohost_wr);
          tohost_d   = tohost_wr;
        end
        default: mmio_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q  <= 64'd0;
      shadow_q <= 32'd0;
      tohost_q <= 32'd0;
      halt_q   <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      shadow_q <= shadow_d;
      tohost_q <= tohost_d;
      halt_q   <= halt_d;
    end
  end

  assign Halt = halt_q;
`else
  assign mmio_hit   = 1'b0;
  assign mmio_rdata = '0;
  assign Halt       = 1'b0;
`endif

  always_comb begin
    read_data_d = '0;
    addr_err_d  = 1'b0;
    if (ram_hit)       read_data_d = ram_word;
    else if (mmio_hit) read_data_d = mmio_rdata;
    else               addr_err_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[word_idx] <= ram_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign ReadData = read_data_q;
  assign AddrErr  = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a randomized run
// against an array-based memory model. MMIO scenarios follow the DMEM_MMIO_EN build.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [3:0]  MemWriteSelect;
  logic [31:0] Addr, WriteData, ReadData;
  logic        Halt, AddrErr;

  int passed = 0;
  int total  = 0;

  dmem_responder dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemWriteSelect(MemWriteSelect),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Halt(Halt), .AddrErr(AddrErr)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic mw, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] wd);
    MemWrite = mw; MemWriteSelect = sel; Addr = a; WriteData = wd;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF);
    tick; tick;
    total++; if (ReadData !== 32'd0) $display("FAIL reset_rdata: got %h want %h", ReadData, 32'd0); else passed++;
    total++; if (AddrErr !== 1'b0) $display("FAIL reset_err: got %b want 0", AddrErr); else passed++;
    total++; if (Halt !== 1'b0) $display("FAIL reset_halt: got %b want 0", Halt); else passed++;
    reset = 1'b0;
    drive(1'b1, 4'hF, 32'h30, 32'hCAFE_F00D); tick;
    total++; if (ReadData !== 32'hCAFE_F00D) $display("FAIL preload_30: got %h want %h", ReadData, 32'hCAFE_F00D); else passed++;
    reset = 1'b1;
    drive(1'b1, 4'hF, 32'h30, 32'h1111_1111); tick;
    total++; if (ReadData !== 32'd0) $display("FAIL reset_write_rdata: got %h want 0", ReadData); else passed++;
    reset = 1'b0;
    drive(1'b0, 4'h0, 32'h30, 32'h0); tick;
    total++; if (ReadData !== 32'hCAFE_F00D) $display("FAIL reset_blocks_write: got %h want %h", ReadData, 32'hCAFE_F00D); else passed++;
  endtask

  task automatic test_byte_lanes;
    drive(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF); tick;
    total++; if (ReadData !== 32'hDEAD_BEEF) $display("FAIL full_write: got %h want %h", ReadData, 32'hDEAD_BEEF); else passed++;
    drive(1'b1, 4'b0010, 32'h10, 32'h0000_AA00); tick;
    total++; if (ReadData !== 32'hDEAD_AAEF) $display("FAIL lane_merge: got %h want %h", ReadData, 32'hDEAD_AAEF); else passed++;
    drive(1'b0, 4'hF, 32'h12, 32'h1234_5678); tick;
    total++; if (ReadData !== 32'hDEAD_AAEF) $display("FAIL sel_ignored_no_write: got %h want %h", ReadData, 32'hDEAD_AAEF); else passed++;
  endtask

  task automatic test_latency_zero_select;
    drive(1'b1, 4'hF, 32'h14, 32'h0BAD_F00D); tick;
    drive(1'b0, 4'h0, 32'h10, 32'h0); #3;
    total++; if (ReadData !== 32'h0BAD_F00D) $display("FAIL early_update: got %h want %h", ReadData, 32'h0BAD_F00D); else passed++;
    tick;
    total++; if (ReadData !== 32'hDEAD_AAEF) $display("FAIL one_cycle_latency: got %h want %h", ReadData, 32'hDEAD_AAEF); else passed++;
    drive(1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF); tick;
    total++; if (ReadData !== 32'hDEAD_AAEF) $display("FAIL zero_sel_same: got %h want %h", ReadData, 32'hDEAD_AAEF); else passed++;
    drive(1'b0, 4'h0, 32'h10, 32'h0); tick;
    total++; if (ReadData !== 32'hDEAD_AAEF) $display("FAIL zero_sel_after: got %h want %h", ReadData, 32'hDEAD_AAEF); else passed++;
  endtask

  task automatic test_write_first;
    drive(1'b1, 4'hF, 32'h20, 32'h1234_5678); tick;
    total++; if (ReadData !== 32'h1234_5678) $display("FAIL write_first: got %h want %h", ReadData, 32'h1234_5678); else passed++;
    total++; if (AddrErr !== 1'b0) $display("FAIL write_first_err: got %b want 0", AddrErr); else passed++;
  endtask

  task automatic test_unmapped;
    drive(1'b1, 4'hF, 32'h0, 32'h55AA_55AA); tick;
    drive(1'b1, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF); tick;
    total++; if (ReadData !== 32'd0) $display("FAIL unmapped_rdata: got %h want 0", ReadData); else passed++;
    total++; if (AddrErr !== 1'b1) $display("FAIL unmapped_err: got %b want 1", AddrErr); else passed++;
    drive(1'b0, 4'h0, 32'h0, 32'h0); tick;
    total++; if (AddrErr !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", AddrErr); else passed++;
    total++; if (ReadData !== 32'h55AA_55AA) $display("FAIL unmapped_discard: got %h want %h", ReadData, 32'h55AA_55AA); else passed++;
    drive(1'b1, 4'hF, 32'hFFC, 32'hA5A5_0FFC); tick;
    total++; if (ReadData !== 32'hA5A5_0FFC || AddrErr !== 1'b0) $display("FAIL last_word: got %h/%b want %h/0", ReadData, AddrErr, 32'hA5A5_0FFC); else passed++;
    drive(1'b0, 4'h0, 32'h1000, 32'h0); tick;
    total++; if (ReadData !== 32'd0 || AddrErr !== 1'b1) $display("FAIL first_unmapped: got %h/%b want 0/1", ReadData, AddrErr); else passed++;
  endtask

`ifdef DMEM_MMIO_EN
  task automatic test_mmio;
    reset = 1'b1; drive(1'b0, 4'h0, 32'hFFFF_0000, 32'h0); tick;
    reset = 1'b0; tick;
    total++; if (ReadData !== 32'd0) $display("FAIL cycle_first: got %h want 0", ReadData); else passed++;
    tick;
    total++; if (ReadData !== 32'd1) $display("FAIL cycle_second: got %h want 1", ReadData); else passed++;
    @(negedge clk); dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
    tick;
    total++; if (ReadData !== 32'hFFFF_FFFE) $display("FAIL snap_lo_a: got %h want %h", ReadData, 32'hFFFF_FFFE); else passed++;
    drive(1'b0, 4'h0, 32'hFFFF_0004, 32'h0); tick;
    total++; if (ReadData !== 32'd0) $display("FAIL snap_hi_a: got %h want 0", ReadData); else passed++;
    drive(1'b0, 4'h0, 32'hFFFF_0000, 32'h0); tick;
    total++; if (ReadData !== 32'd0) $display("FAIL snap_lo_b: got %h want 0", ReadData); else passed++;
    drive(1'b0, 4'h0, 32'hFFFF_0004, 32'h0); tick;
    total++; if (ReadData !== 32'd1) $display("FAIL snap_hi_b: got %h want 1", ReadData); else passed++;
    drive(1'b1, 4'hF, 32'hFFFF_0000, 32'hFFFF_FFFF); tick;
    total++; if (ReadData !== 32'd2 || AddrErr !== 1'b0) $display("FAIL cycle_ro: got %h/%b want 2/0", ReadData, AddrErr); else passed++;
    drive(1'b1, 4'hF, 32'hFFFF_000C, 32'hFFFF_FFFF); tick;
    total++; if (ReadData !== 32'd0 || AddrErr !== 1'b0) $display("FAIL reserved_c: got %h/%b want 0/0", ReadData, AddrErr); else passed++;
    drive(1'b1, 4'b0001, 32'hFFFF_0008, 32'hFFFF_FF01); tick;
    total++; if (ReadData !== 32'd1 || Halt !== 1'b0) $display("FAIL tohost_write: got %h/%b want 1/0", ReadData, Halt); else passed++;
    drive(1'b0, 4'h0, 32'hFFFF_0008, 32'h0); tick;
    total++; if (Halt !== 1'b1) $display("FAIL halt_set: got %b want 1", Halt); else passed++;
    tick; tick;
    total++; if (Halt !== 1'b1 || ReadData !== 32'd1) $display("FAIL halt_sticky: got %b/%h want 1/1", Halt, ReadData); else passed++;
    reset = 1'b1; tick;
    reset = 1'b0; tick;
    total++; if (Halt !== 1'b0 || ReadData !== 32'd0) $display("FAIL halt_reset: got %b/%h want 0/0", Halt, ReadData); else passed++;
  endtask
`else
  task automatic test_mmio;
    drive(1'b0, 4'h0, 32'hFFFF_0000, 32'h0); tick;
    total++; if (ReadData !== 32'd0 || AddrErr !== 1'b1) $display("FAIL mmio_off_read: got %h/%b want 0/1", ReadData, AddrErr); else passed++;
    drive(1'b1, 4'hF, 32'hFFFF_0008, 32'h1); tick;
    total++; if (AddrErr !== 1'b1) $display("FAIL mmio_off_write: got %b want 1", AddrErr); else passed++;
    drive(1'b0, 4'h0, 32'h0, 32'h0); tick; tick;
    total++; if (Halt !== 1'b0) $display("FAIL mmio_off_halt: got %b want 0", Halt); else passed++;
  endtask
`endif

  task automatic test_random;
    logic [31:0] model [1024];
    int          idxs [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 1023};
    logic [31:0] a, wd, exp_rd;
    logic [3:0]  sel;
    logic        mw, exp_err;
    int          idx, kind;
    for (int k = 0; k < 9; k++) begin
      wd = $urandom;
      drive(1'b1, 4'hF, idxs[k] * 4, wd); tick;
      model[idxs[k]] = wd;
      total++; if (ReadData !== wd) $display("FAIL rand_init[%0d]: got %h want %h", k, ReadData, wd); else passed++;
    end
    for (int n = 0; n < 300; n++) begin
      mw   = 1'($urandom_range(0, 1));
      sel  = 4'($urandom);
      wd   = $urandom;
      idx  = idxs[$urandom_range(0, 8)];
      kind = $urandom_range(0, 9);
      if (kind < 8)       a = idx * 4 + $urandom_range(0, 3);
      else if (kind == 8) a = 32'h1000 + idx * 4;
      else                a = 32'h8000_0000 | (idx * 4);
      if (a < 32'h1000) begin
        if (mw) for (int l = 0; l < 4; l++) if (sel[l]) model[idx][8*l +: 8] = wd[8*l +: 8];
        exp_rd  = model[idx];
        exp_err = 1'b0;
      end else begin
        exp_rd  = 32'd0;
        exp_err = 1'b1;
      end
      drive(mw, sel, a, wd); tick;
      total++; if (ReadData !== exp_rd || AddrErr !== exp_err)
        $display("FAIL rand[%0d] addr=%h: got %h/%b want %h/%b", n, a, ReadData, AddrErr, exp_rd, exp_err);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    test_reset();
    test_byte_lanes();
    test_latency_zero_select();
    test_write_first();
    test_unmapped();
    test_mmio();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
